// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared FSM state and op encodings for the stack arbiter
package stack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic OP_POP  = 1'b0;
  localparam logic OP_PUSH = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin grant with a last-grant register
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // High when requester 1 won last, so requester 0 has priority next.
  logic last_q;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) grant = last_q ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset)              last_q <= 1'b1;
    else if (grant != 2'b00) last_q <= grant[1];
  end

endmodule

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - serialises push/pop requests from two clients onto one stack
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int POP_LATENCY = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                req_valid,
  input  logic [1:0]                req_op,
  input  logic [2*DATA_WIDTH-1:0]   req_data,
  output logic [1:0]                req_ready,
  output logic [1:0]                rsp_valid,
  output logic                      rsp_err,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      stk_push,
  output logic                      stk_pop,
  output logic [DATA_WIDTH-1:0]     stk_inp_data,
  input  logic [DATA_WIDTH-1:0]     stk_out_data,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [2:0] WAIT_LAST = 3'(POP_LATENCY > 1 ? POP_LATENCY - 2 : 0);

  state_t                state_q, state_d;
  logic [1:0]            grant;
  logic                  arb_en;
  logic                  gnt_idx_q;
  logic                  op_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [OCC_W-1:0]      occ_q;
  logic [2:0]            wait_cnt_q;
  logic                  issue_ok;

  // Grants are only offered in IDLE and never while reset is held.
  assign arb_en = (state_q == ST_IDLE) && reset;

  rr_arbiter2 u_arb (
    .clock (clock),
    .reset (reset),
    .en    (arb_en),
    .req   (req_valid),
    .grant (grant)
  );

  assign issue_ok = (op_q == OP_PUSH) ? (occ_q != OCC_W'(DEPTH)) : (occ_q != '0);

  always_comb begin
    state_d      = state_q;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
    stk_inp_data = '0;
    case (state_q)
      ST_IDLE:  if (grant != 2'b00) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (!issue_ok) begin
          state_d = ST_RESP;
        end else if (op_q == OP_PUSH) begin
          stk_push     = 1'b1;
          stk_inp_data = data_q;
          state_d      = ST_RESP;
        end else begin
          stk_pop = 1'b1;
          state_d = (POP_LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT:  if (wait_cnt_q == WAIT_LAST) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= 1'b0;
      op_q       <= OP_POP;
      data_q     <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      occ_q      <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && grant != 2'b00) begin
        gnt_idx_q <= grant[1];
        op_q      <= grant[1] ? req_op[1] : req_op[0];
        data_q    <= grant[1] ? req_data[2*DATA_WIDTH-1:DATA_WIDTH] : req_data[DATA_WIDTH-1:0];
      end
      if (state_q == ST_ISSUE) begin
        err_q      <= !issue_ok;
        wait_cnt_q <= '0;
        if (issue_ok && op_q == OP_PUSH) occ_q <= occ_q + OCC_W'(1);
        if (issue_ok && op_q == OP_POP) begin
          occ_q <= occ_q - OCC_W'(1);
          if (POP_LATENCY == 1) rsp_data_q <= stk_out_data;
        end
      end
      if (state_q == ST_WAIT) begin
        wait_cnt_q <= wait_cnt_q + 3'd1;
        if (wait_cnt_q == WAIT_LAST) rsp_data_q <= stk_out_data;
      end
    end
  end

  assign req_ready = grant;
  assign rsp_valid = (state_q == ST_RESP) ? (gnt_idx_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_err   = (state_q == ST_RESP) && err_q;
  assign rsp_data  = rsp_data_q;
  assign occupancy = occ_q;

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the stack word width.
REQ-002 SHALL have parameter DEPTH, default 32, the stack capacity in words; the occupancy counter is $clog2(DEPTH)+1 bits.
REQ-003 SHALL have parameter POP_LATENCY, default 2, the cycles from stk_pop high to valid stk_out_data; legal range 1..7.
REQ-004 SHALL have ports: clock in 1, the single clock; reset in 1, synchronous active-low reset.
REQ-005 SHALL have ports: req_valid in 2, one bit per requester; req_op in 2, 1=push 0=pop per requester; req_data in 2*DATA_WIDTH, push data with requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have ports: req_ready out 2, one-hot grant; rsp_valid out 2, one-cycle completion pulse; rsp_err out 1, rejected op; rsp_data out DATA_WIDTH, pop result.
REQ-007 SHALL have ports: stk_push out 1, stk_pop out 1, stk_inp_data out DATA_WIDTH, stk_out_data in DATA_WIDTH; occupancy out $clog2(DEPTH)+1, word count.

Function
REQ-008 SHALL serialise requests with exactly one op in flight, using FSM IDLE, ISSUE, WAIT, RESP.
REQ-009 In IDLE with any req_valid, SHALL grant one requester by round-robin, priority to the requester not granted last; req_ready is high for exactly that cycle; op and data are latched; next state is ISSUE.
REQ-010 Requester i SHALL hold req_valid, req_op and req_data stable until req_ready[i] is high; a transfer occurs only when req_valid[i] and req_ready[i] are both high.
REQ-011 In ISSUE, SHALL drive a one-cycle stk_push (latched data on stk_inp_data) or a one-cycle stk_pop, never both; a legal push goes to RESP; a legal pop goes to WAIT.
REQ-012 A push with occupancy==DEPTH, or a pop with occupancy==0, SHALL issue no stack strobe, go directly to RESP, and flag rsp_err.
REQ-013 In WAIT, SHALL count POP_LATENCY-1 cycles, then sample stk_out_data into the rsp_data register and go to RESP.
REQ-014 In RESP, SHALL pulse rsp_valid[granted] for one cycle with rsp_err and rsp_data valid, then return to IDLE; the arbiter does not grant in RESP.
REQ-015 Occupancy SHALL increment in the ISSUE cycle of a legal push, decrement in the ISSUE cycle of a legal pop, and otherwise hold; it never wraps.
REQ-016 Latency (grant to rsp_valid) SHALL be 2 cycles for a push or rejected op, and POP_LATENCY+1 cycles for a legal pop.
REQ-017 If both requesters are valid continuously, grants SHALL alternate 0,1,0,1; the first grant after reset goes to requester 0.
REQ-018 rsp_data SHALL hold its last pop value until the next legal pop completes; rsp_data is not updated on a push or a rejected op.

Reset
REQ-019 On a clock edge with reset low, SHALL set state=IDLE, occupancy=0, last-grant so requester 0 wins next, and all outputs to 0 (req_ready, rsp_valid, rsp_err, rsp_data, stk_push, stk_pop, stk_inp_data).
REQ-020 Reset asserted mid-operation SHALL abandon the in-flight op with no rsp_valid; the stack must be reset in the same cycle by the integrating level.

Structure
REQ-021 The FSM state enum and the op encoding (OP_POP=0, OP_PUSH=1) SHALL live in the shared package stack_pkg.
REQ-022 SHALL instantiate one sub-module, rr_arbiter2 (two-input round-robin grant with last-grant register); all remaining logic is inline.

Verification
REQ-023 Reset, then requester 0 pushes 0xA5A5A5A5 -> req_ready[0] in cycle 1, stk_push pulse in cycle 2, rsp_valid[0] in cycle 3, occupancy=1.
REQ-024 Push 0x11, push 0x22 (requester 1), then pop (requester 0) -> rsp_data=0x22 exactly POP_LATENCY+1 cycles after the pop grant; occupancy=1.
REQ-025 Pop at occupancy 0 -> no stk_pop, rsp_valid with rsp_err=1, occupancy stays 0; push at occupancy DEPTH -> rsp_err=1, no stk_push.
REQ-026 Both requesters hold req_valid for 8 ops -> grant order 0,1,0,1,0,1,0,1, and no two grants less than 3 cycles apart.
REQ-027 Drive reset low during WAIT of a pop -> no rsp_valid, occupancy=0 the next cycle, and the next grant goes to requester 0.
